// File: rtl/midori_sbox_serializer.sv
// Serializer/deserializer around a 3-share pipelined Midori S-box.
// A 64-bit state in three Boolean shares is fed one nibble per cycle,
// LSB nibble first. The S-box outputs are re-collected SBOX_LAT cycles
// later, with no valid strobe from the S-box. Each share has its own lane,
// and no lane ever sees another share. The lanes share only control signals,
// which come from the cycle counter and the state machine.

module midori_share_lane #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         cap_en,
  input  logic         finish,
  input  logic [W-1:0] din,
  input  logic [3:0]   sbo,
  output logic [3:0]   nib,
  output logic [W-1:0] res
);

  logic [W-1:0] feed;
  logic [W-1:0] cap;

  // Feed shift register, registered S-box input, capture register and held result for one share
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feed <= '0;
      nib  <= '0;
      cap  <= '0;
      res  <= '0;
    end else begin
      if (load) begin
        nib  <= din[3:0];
        feed <= din >> 4;
      end else if (shift) begin
        nib  <= feed[3:0];
        feed <= feed >> 4;
      end else begin
        nib  <= '0;
      end
      // Newest output enters at the top, so the first nibble ends up at the bottom
      if (cap_en) begin
        cap <= {sbo, cap[W-1:4]};
      end
      if (finish) begin
        res <= {sbo, cap[W-1:4]};
      end
    end
  end

endmodule

module midori_sbox_serializer #(
  parameter int SBOX_LAT = 3,
  parameter int NIBBLES  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] in_share1,
  input  logic [4*NIBBLES-1:0] in_share2,
  input  logic [4*NIBBLES-1:0] in_share3,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] out_share1,
  output logic [4*NIBBLES-1:0] out_share2,
  output logic [4*NIBBLES-1:0] out_share3,
  output logic [3:0]           sb_in1,
  output logic [3:0]           sb_in2,
  output logic [3:0]           sb_in3,
  input  logic [3:0]           sb_out1,
  input  logic [3:0]           sb_out2,
  input  logic [3:0]           sb_out3
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + SBOX_LAT + 1);

  // Counter values are the cycle number since the accepting edge
  localparam logic [CW-1:0] LAST_FEED = CW'(NIBBLES - 1);
  localparam logic [CW-1:0] CAP_FIRST = CW'(SBOX_LAT);
  localparam logic [CW-1:0] CAP_LAST  = CW'(NIBBLES - 1 + SBOX_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          load;
  logic          shift;
  logic          cap_en;
  logic          finish;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and lane controls, all derived from state and the cycle counter
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    cap_en    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = FEED;
        end
      end
      FEED: begin
        busy   = 1'b1;
        cap_en = (cnt >= CAP_FIRST);
        if (cnt == LAST_FEED) begin
          state_nxt = DRAIN;
        end else begin
          shift = 1'b1;
        end
      end
      DRAIN: begin
        busy   = 1'b1;
        cap_en = (cnt >= CAP_FIRST);
        if (cnt == CAP_LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Cycle counter (cleared on accept) and the registered completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  midori_share_lane #(.W(W)) u_lane1 (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .cap_en(cap_en), .finish(finish),
    .din(in_share1), .sbo(sb_out1), .nib(sb_in1), .res(out_share1)
  );

  midori_share_lane #(.W(W)) u_lane2 (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .cap_en(cap_en), .finish(finish),
    .din(in_share2), .sbo(sb_out2), .nib(sb_in2), .res(out_share2)
  );

  midori_share_lane #(.W(W)) u_lane3 (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .cap_en(cap_en), .finish(finish),
    .din(in_share3), .sbo(sb_out3), .nib(sb_in3), .res(out_share3)
  );

endmodule

// File: tb/tb_midori_sbox_serializer.sv
// Directed bench for midori_sbox_serializer: a 3-cycle masked Sb0 model
// drives the default instance, and a 1-cycle identity model drives a
// SBOX_LAT=1 instance.

module tb_midori_sbox_serializer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_b;
  logic [63:0] in_share1, in_share2, in_share3;

  logic        busy, done;
  logic [63:0] out_share1, out_share2, out_share3;
  logic [3:0]  sb_in1, sb_in2, sb_in3;
  logic [3:0]  sb_out1, sb_out2, sb_out3;

  logic        busy_b, done_b;
  logic [63:0] out_b1, out_b2, out_b3;
  logic [3:0]  sbi_b1, sbi_b2, sbi_b3;
  logic [3:0]  sbo_b1, sbo_b2, sbo_b3;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] ST  = 64'h0123456789ABCDEF;
  localparam logic [63:0] SB  = 64'hCAD3EBF789150246;
  localparam logic [63:0] M2  = 64'h3C5A9F017E26B4D8;
  localparam logic [63:0] M3  = 64'h1234ABCD55660F9E;
  localparam logic [63:0] ALL = 64'hFFFFFFFFFFFFFFFF;

  midori_sbox_serializer #(.SBOX_LAT(3), .NIBBLES(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_share1(in_share1), .in_share2(in_share2), .in_share3(in_share3),
    .busy(busy), .done(done),
    .out_share1(out_share1), .out_share2(out_share2), .out_share3(out_share3),
    .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3),
    .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
  );

  midori_sbox_serializer #(.SBOX_LAT(1), .NIBBLES(16)) dut1 (
    .clk(clk), .rst(rst), .start(start_b),
    .in_share1(in_share1), .in_share2(in_share2), .in_share3(in_share3),
    .busy(busy_b), .done(done_b),
    .out_share1(out_b1), .out_share2(out_b2), .out_share3(out_b3),
    .sb_in1(sbi_b1), .sb_in2(sbi_b2), .sb_in3(sbi_b3),
    .sb_out1(sbo_b1), .sb_out2(sbo_b2), .sb_out3(sbo_b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] sb0(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h6420_5198_7FBE_3DAC;
    return tbl[4*x +: 4];
  endfunction

  // Masked S-box model: output shares XOR to Sb0 of the input shares' XOR
  function automatic logic [11:0] sbox_model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {sb0(a ^ b ^ c) ^ b ^ c, b, c};
  endfunction

  logic [11:0] pipe0, pipe1, pipe2;
  always_ff @(posedge clk) begin
    pipe0 <= sbox_model(sb_in1, sb_in2, sb_in3);
    pipe1 <= pipe0;
    pipe2 <= pipe1;
  end
  assign {sb_out1, sb_out2, sb_out3} = pipe2;

  logic [11:0] id_r;
  always_ff @(posedge clk) id_r <= {sbi_b1, sbi_b2, sbi_b3};
  assign {sbo_b1, sbo_b2, sbo_b3} = id_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          first_cyc, second_cyc, ndone, busy_err;
  logic [63:0] res_first, res_mid, res_last;
  logic [11:0] sbi_c0, sbi_c16;

  // Start one operation, optionally pulse start again in cycle `extra` with new inputs
  task automatic op(input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] s3,
                    input int extra, input logic [63:0] x1, input logic [63:0] x2, input logic [63:0] x3);
    logic exp_busy;
    @(negedge clk);
    in_share1 = s1; in_share2 = s2; in_share3 = s3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_cyc = -1; second_cyc = -1; ndone = 0; busy_err = 0;
    res_first = '0; res_mid = '0; res_last = '0;
    for (int n = 0; n < 42; n++) begin
      if (done) begin
        ndone++;
        if (first_cyc < 0) begin
          first_cyc = n;
          res_first = out_share1 ^ out_share2 ^ out_share3;
        end else begin
          second_cyc = n;
          res_last = out_share1 ^ out_share2 ^ out_share3;
        end
      end
      if (n == 30) res_mid = out_share1 ^ out_share2 ^ out_share3;
      if (n == 0)  sbi_c0  = {sb_in1, sb_in2, sb_in3};
      if (n == 16) sbi_c16 = {sb_in1, sb_in2, sb_in3};
      exp_busy = (n < 19) || (extra == 19 && n >= 20 && n < 39);
      if (busy !== exp_busy) busy_err++;
      if (n == extra) begin
        start = 1'b1;
        in_share1 = x1; in_share2 = x2; in_share3 = x3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc_b;
    rst = 1'b1; start = 1'b0; start_b = 1'b0;
    in_share1 = '0; in_share2 = '0; in_share3 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sbin", 64'({sb_in1, sb_in2, sb_in3}), 64'd0);
    check("reset_out", out_share1 | out_share2 | out_share3, 64'd0);
    rst = 1'b0;

    // Unmasked state
    op(ST, 64'd0, 64'd0, -1, 64'd0, 64'd0, 64'd0);
    check("unmasked_done_cycle", 64'(first_cyc), 64'd19);
    check("unmasked_ndone", 64'(ndone), 64'd1);
    check("unmasked_result", res_first, SB);
    check("unmasked_busy", 64'(busy_err), 64'd0);
    check("unmasked_sbin_c0", 64'(sbi_c0), 64'h00000000_00000F00);
    check("unmasked_sbin_c16", 64'(sbi_c16), 64'd0);

    // Same state under random masks
    op(ST ^ M2 ^ M3, M2, M3, -1, 64'd0, 64'd0, 64'd0);
    check("masked_result", res_first, SB);
    check("masked_busy", 64'(busy_err), 64'd0);
    check("masked_sbin_c0", 64'(sbi_c0), 64'h00000000_0000098E);
    check("masked_done_cycle", 64'(first_cyc), 64'd19);

    // Extra start in cycle 5 must be ignored
    op(ST, 64'd0, 64'd0, 5, ALL, 64'd0, 64'd0);
    check("busy_start_ndone", 64'(ndone), 64'd1);
    check("busy_start_result", res_first, SB);
    check("busy_start_cycle", 64'(first_cyc), 64'd19);

    // Back-to-back: new start in the done cycle
    op(ST, 64'd0, 64'd0, 19, ALL, 64'd0, 64'd0);
    check("b2b_first", res_first, SB);
    check("b2b_gap", 64'(second_cyc - first_cyc), 64'd20);
    check("b2b_held", res_mid, SB);
    check("b2b_second", res_last, 64'h6666666666666666);
    check("b2b_busy", 64'(busy_err), 64'd0);

    // Asynchronous reset in cycle 10
    @(negedge clk);
    in_share1 = ST; in_share2 = M2; in_share3 = M3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sbin", 64'({sb_in1, sb_in2, sb_in3}), 64'd0);
    check("rst_out", out_share1 | out_share2 | out_share3, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    op(ST ^ M2, M2, 64'd0, -1, 64'd0, 64'd0, 64'd0);
    check("post_rst_cycle", 64'(first_cyc), 64'd19);
    check("post_rst_result", res_first, SB);

    // SBOX_LAT=1 instance with identity S-box
    @(negedge clk);
    in_share1 = ST; in_share2 = M2; in_share3 = M3;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc_b = -1;
    for (int n = 0; n < 30; n++) begin
      if (done_b && cyc_b < 0) cyc_b = n;
      @(negedge clk);
    end
    check("lat1_done_cycle", 64'(cyc_b), 64'd17);
    check("lat1_share1", out_b1, ST);
    check("lat1_share2", out_b2, M2);
    check("lat1_share3", out_b3, M3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/midori_sbox_serializer.md
Name: midori_sbox_serializer

Overview:
- Upstream/downstream controller for the team's 3-share masked Midori S-box (3-cycle pipeline, 4-bit nibble per share, no enable or stall).
- Accepts a full 64-bit state in three Boolean shares on a start pulse.
- Streams the 16 nibbles into the S-box one per cycle, then re-collects the pipelined outputs into a 64-bit 3-share result.
- Sits between the round state register (key/round-constant addition) and the MixColumn/ShuffleCell layer.

Parameters:
- SBOX_LAT, 3, cycles from a nibble driven on sb_in* to its S-box output on sb_out*; legal range 1..7.
- NIBBLES, 16, nibbles per state; fixed at 16 for Midori64; only value verified.

Ports:
- clk  input  1  clock; all flops rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- in_share1  input  64  state share 1; nibble k = bits [4k+3:4k].
- in_share2  input  64  state share 2.
- in_share3  input  64  state share 3.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; out_share* valid in this cycle.
- out_share1  output  64  result share 1; held until the next accepted start.
- out_share2  output  64  result share 2.
- out_share3  output  64  result share 3.
- sb_in1  output  4  nibble share 1 to the S-box; registered.
- sb_in2  output  4  nibble share 2 to the S-box; registered.
- sb_in3  output  4  nibble share 3 to the S-box; registered.
- sb_out1  input  4  S-box output share 1.
- sb_out2  input  4  S-box output share 2.
- sb_out3  input  4  S-box output share 3.

Behaviour:
- Reset (asynchronous, no clock needed): state=IDLE; all counters and shift registers 0; busy=0, done=0, sb_in*=0, out_share*=0.
- Share isolation:
  - One independent shift register and capture register per share.
  - No logic combines two shares, and no share is ever XORed or compared with another.
  - Control signals derive only from counters and the state machine.
- Cycle numbering: E0 = the edge that samples start=1 in IDLE; cycle n = the cycle after edge E0+n.
- IDLE:
  - start=1 → load the three input shares into the feed shift registers, clear the feed and capture counters, go to FEED.
  - start=0 → stay in IDLE; sb_in*=0.
- FEED:
  - sb_in* carries nibble k of each share during cycle k, k=0..15, LSB nibble first.
  - Feed registers shift right by 4 each cycle.
  - After nibble 15 → go to DRAIN; sb_in* returns to 0 from cycle 16 onward.
- Capture (overlaps FEED and DRAIN):
  - In cycle k+SBOX_LAT, sb_out* is sampled into the capture registers: each shifts right by 4 and inserts at bits [63:60].
  - After 16 captures, nibble k sits at bits [4k+3:4k].
  - Capture is enabled by a delay counter started at E0, not by a sb_out* valid signal (the S-box has none).
- Done:
  - Captures occupy cycles SBOX_LAT..15+SBOX_LAT.
  - out_share* updates and done=1 in cycle 16+SBOX_LAT (cycle 19 for the default).
  - The state returns to IDLE in the same cycle; busy=0 in that cycle.
- busy=1 for cycles 0..15+SBOX_LAT.
- start while busy is ignored, with no queueing.
- start in the done cycle is accepted (state is already IDLE); out_share* stays held until the first new capture completes.
- out_share* changes only at completion; intermediate captures are not visible.
- Reset asserted mid-operation aborts immediately to the reset values; no done is produced.

Test Plan:
- Unmasked: in_share1=0x0123456789ABCDEF, in_share2=in_share3=0, start at E0 → done exactly in cycle 19; out_share1^out_share2^out_share3=0xCAD3EBF789150246 (Midori Sb0).
- Random masks: the same state split with random in_share2/in_share3 → same XOR result 0xCAD3EBF789150246; busy high for cycles 0..18.
- Back-to-back: start asserted in the done cycle with state 0xFFFFFFFFFFFFFFFF → second done 20 edges after the first; XOR result 0x6666666666666666.
- Start while busy: an extra start pulse in cycle 5 → exactly one done; result unchanged.
- Reset mid-run: rst asserted in cycle 10 → busy, done, sb_in* and out_share* at 0 without waiting for a clock edge; a new start completes normally.
- Latency parameter: SBOX_LAT=1 with a bench identity S-box model of 1-cycle delay → out_share*=in_share* per share; done in cycle 17.
